// File: rtl/blk_shiftreg_param_pkg.sv
// Shared sizing and state encoding for the interleaver input block buffer.
// Block sizes are expressed in bits; depths are derived in bytes.
package blk_shiftreg_param_pkg;

  localparam int BYTE_W    = 8;
  localparam int K_SMALL   = 1056;
  localparam int K_LARGE   = 6144;
  localparam int DEPTH_SM  = K_SMALL / BYTE_W;
  localparam int DEPTH_MAX = K_LARGE / BYTE_W;
  localparam int CNT_W     = $clog2(DEPTH_MAX + 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/blk_shiftreg_param_if.sv
// Byte-stream input and held-block output bundle of the block buffer.
// The slave modport is the buffer; the master modport is its producer/consumer.
interface blk_shiftreg_param_if #(
  parameter int BYTE_W    = blk_shiftreg_param_pkg::BYTE_W,
  parameter int DEPTH_MAX = blk_shiftreg_param_pkg::DEPTH_MAX,
  parameter int DEPTH_SM  = blk_shiftreg_param_pkg::DEPTH_SM,
  parameter int CNT_W     = blk_shiftreg_param_pkg::CNT_W
) ();

  logic                          i_mode;
  logic                          i_valid;
  logic [BYTE_W-1:0]             i_data;
  logic                          o_ready;
  logic                          i_release;
  logic                          o_blk_full;
  logic                          o_blk_done;
  logic                          o_blk_mode;
  logic [CNT_W-1:0]              o_fill_cnt;
  logic [DEPTH_MAX*BYTE_W-1:0]   o_q_large;
  logic [DEPTH_SM*BYTE_W-1:0]    o_q_small;
  logic [BYTE_W-1:0]             o_shift_out;
  logic                          o_shift_en;

  modport master (
    output i_mode, i_valid, i_data, i_release,
    input  o_ready, o_blk_full, o_blk_done, o_blk_mode, o_fill_cnt,
           o_q_large, o_q_small, o_shift_out, o_shift_en
  );

  modport slave (
    input  i_mode, i_valid, i_data, i_release,
    output o_ready, o_blk_full, o_blk_done, o_blk_mode, o_fill_cnt,
           o_q_large, o_q_small, o_shift_out, o_shift_en
  );

endinterface

// File: rtl/blk_shiftreg_param_fill_ctrl.sv
// Fill/hold controller: counts accepted bytes, latches the block mode on the
// first byte and holds the block from the final accept until release.
module blk_shiftreg_param_fill_ctrl
  import blk_shiftreg_param_pkg::*;
#(
  parameter int DEPTH_MAX_P = DEPTH_MAX,
  parameter int DEPTH_SM_P  = DEPTH_SM,
  parameter int CNT_W_P     = CNT_W
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               i_sclr,
  input  logic               i_mode,
  input  logic               i_valid,
  input  logic               i_release,
  output logic               o_ready,
  output logic               o_accept,
  output logic               o_blk_full,
  output logic               o_blk_done,
  output logic               o_blk_mode,
  output logic [CNT_W_P-1:0] o_fill_cnt
);

  fill_state_e        r_state;
  logic               r_blk_full;
  logic               r_blk_done;
  logic               r_blk_mode;
  logic [CNT_W_P-1:0] r_fill_cnt;

  logic               w_ready;
  logic               w_accept;
  logic               w_mode_eff;
  logic [CNT_W_P-1:0] w_target;
  logic [CNT_W_P-1:0] w_cnt_nxt;

  // The first byte of a block sees the live mode input since nothing is latched yet
  always_comb begin
    w_ready    = (r_state == ST_FILL);
    w_accept   = i_valid & w_ready;
    w_mode_eff = (r_fill_cnt == {CNT_W_P{1'b0}}) ? i_mode : r_blk_mode;
    w_target   = w_mode_eff ? CNT_W_P'(DEPTH_MAX_P) : CNT_W_P'(DEPTH_SM_P);
    w_cnt_nxt  = r_fill_cnt + CNT_W_P'(1);
  end

  // Fill/hold state machine with registered status outputs
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state    <= ST_FILL;
      r_blk_full <= 1'b0;
      r_blk_done <= 1'b0;
      r_blk_mode <= 1'b0;
      r_fill_cnt <= {CNT_W_P{1'b0}};
    end else if (i_sclr) begin
      r_state    <= ST_FILL;
      r_blk_full <= 1'b0;
      r_blk_done <= 1'b0;
      r_blk_mode <= 1'b0;
      r_fill_cnt <= {CNT_W_P{1'b0}};
    end else begin
      r_blk_done <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_blk_mode <= w_mode_eff;
            r_fill_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == w_target) begin
              r_state    <= ST_FULL;
              r_blk_full <= 1'b1;
              r_blk_done <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (i_release) begin
            r_state    <= ST_FILL;
            r_blk_full <= 1'b0;
            r_fill_cnt <= {CNT_W_P{1'b0}};
          end
        end
        default: begin
          r_state    <= ST_FILL;
          r_blk_full <= 1'b0;
          r_fill_cnt <= {CNT_W_P{1'b0}};
        end
      endcase
    end
  end

  assign o_ready    = w_ready;
  assign o_accept   = w_accept;
  assign o_blk_full = r_blk_full;
  assign o_blk_done = r_blk_done;
  assign o_blk_mode = r_blk_mode;
  assign o_fill_cnt = r_fill_cnt;

endmodule

// File: rtl/blk_shiftreg_param.sv
// Byte-wide block buffer: bytes enter at the top and move down one byte per
// accept; the controller freezes the register once a block is complete.
module blk_shiftreg_param #(
  parameter int BYTE_W    = blk_shiftreg_param_pkg::BYTE_W,
  parameter int DEPTH_MAX = blk_shiftreg_param_pkg::DEPTH_MAX,
  parameter int DEPTH_SM  = blk_shiftreg_param_pkg::DEPTH_SM,
  parameter int CNT_W     = blk_shiftreg_param_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 i_sclr,
  blk_shiftreg_param_if.slave  io_bus
);

  localparam int MEM_W = DEPTH_MAX * BYTE_W;
  localparam int SM_W  = DEPTH_SM * BYTE_W;

  logic [MEM_W-1:0] r_mem;
  logic             w_accept;
  logic             w_ready;
  logic             w_blk_full;
  logic             w_blk_done;
  logic             w_blk_mode;
  logic [CNT_W-1:0] w_fill_cnt;

  blk_shiftreg_param_fill_ctrl #(
    .DEPTH_MAX_P (DEPTH_MAX),
    .DEPTH_SM_P  (DEPTH_SM),
    .CNT_W_P     (CNT_W)
  ) u_fill_ctrl (
    .clk        (clk),
    .aclr       (aclr),
    .i_sclr     (i_sclr),
    .i_mode     (io_bus.i_mode),
    .i_valid    (io_bus.i_valid),
    .i_release  (io_bus.i_release),
    .o_ready    (w_ready),
    .o_accept   (w_accept),
    .o_blk_full (w_blk_full),
    .o_blk_done (w_blk_done),
    .o_blk_mode (w_blk_mode),
    .o_fill_cnt (w_fill_cnt)
  );

  // Data register; release leaves old contents in place so they drain via the bottom byte
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_mem <= {MEM_W{1'b0}};
    end else if (i_sclr) begin
      r_mem <= {MEM_W{1'b0}};
    end else if (w_accept) begin
      r_mem <= {io_bus.i_data, r_mem[MEM_W-1:BYTE_W]};
    end
  end

  assign io_bus.o_ready     = w_ready;
  assign io_bus.o_shift_en  = w_accept;
  assign io_bus.o_blk_full  = w_blk_full;
  assign io_bus.o_blk_done  = w_blk_done;
  assign io_bus.o_blk_mode  = w_blk_mode;
  assign io_bus.o_fill_cnt  = w_fill_cnt;
  assign io_bus.o_q_large   = r_mem;
  assign io_bus.o_q_small   = r_mem[MEM_W-1 -: SM_W];
  assign io_bus.o_shift_out = r_mem[BYTE_W-1:0];

endmodule

// File: tb/tb_blk_shiftreg_param.sv
// Randomised bench for blk_shiftreg_param: a byte-history model predicts every
// cycle and queues completed blocks for a monitor that checks them on blk_done.
module tb_blk_shiftreg_param;
  import blk_shiftreg_param_pkg::*;

  localparam int QW = DEPTH_MAX * BYTE_W;
  localparam int SW = DEPTH_SM * BYTE_W;

  logic clk = 1'b0;
  logic aclr;
  logic sclr;
  always #5 clk = ~clk;

  blk_shiftreg_param_if bus ();
  blk_shiftreg_param dut (.clk(clk), .aclr(aclr), .i_sclr(sclr), .io_bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [QW-1:0]    q;
    logic [CNT_W-1:0] cnt;
    logic             mode;
  } exp_t;
  exp_t exp_q[$];

  // Model: hist[j] is the byte expected at q_large[8j+7:8j]; hist[DEPTH_MAX-1] is newest
  logic [7:0] hist[$];
  int m_cnt;
  bit m_held, m_mode, m_done;

  function automatic logic [QW-1:0] model_vec();
    logic [QW-1:0] v;
    for (int j = 0; j < DEPTH_MAX; j++) v[j*BYTE_W +: BYTE_W] = hist[j];
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (DEPTH_MAX) hist.push_back(8'h00);
    m_cnt = 0; m_held = 1'b0; m_mode = 1'b0; m_done = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int j = 0; j < DEPTH_MAX; j++) begin
        if (act[j*BYTE_W +: BYTE_W] !== exp[j*BYTE_W +: BYTE_W]) begin
          $display("FAIL %s byte %0d actual=%0h expected=%0h at %0t", nm, j,
                   act[j*BYTE_W +: BYTE_W], exp[j*BYTE_W +: BYTE_W], $time);
          break;
        end
      end
    end
  endtask

  // One clock cycle: drive after negedge, check comb, advance model, check registered state
  task automatic step(input bit v, input logic [7:0] d, input bit m, input bit r, input bit s);
    exp_t e;
    bus.i_valid = v; bus.i_data = d; bus.i_mode = m; bus.i_release = r; sclr = s;
    #1;
    chk("in_ready", bus.o_ready, !m_held);
    if (!s) chk("shift_en", bus.o_shift_en, v && !m_held);
    m_done = 1'b0;
    if (s) begin
      model_reset();
    end else if (!m_held) begin
      if (v) begin
        if (m_cnt == 0) m_mode = m;
        m_cnt++;
        hist.push_back(d);
        void'(hist.pop_front());
        if (m_cnt == (m_mode ? DEPTH_MAX : DEPTH_SM)) begin
          m_held = 1'b1; m_done = 1'b1;
          e.q = model_vec(); e.cnt = CNT_W'(m_cnt); e.mode = m_mode;
          exp_q.push_back(e);
        end
      end
    end else if (r) begin
      m_held = 1'b0; m_cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("fill_cnt", bus.o_fill_cnt, m_cnt);
    chk("blk_full", bus.o_blk_full, m_held);
    chk("blk_done", bus.o_blk_done, m_done);
    chk("blk_mode", bus.o_blk_mode, m_mode);
    chk("shift_out", bus.o_shift_out, hist[0]);
    chk("q_top_byte", bus.o_q_large[QW-1 -: 8], hist[DEPTH_MAX-1]);
    chk("q_small_low", bus.o_q_small[7:0], hist[DEPTH_MAX-DEPTH_SM]);
  endtask

  // Offer exactly n bytes; kind 0: index, 1: index+1, 2: random. Mode flips from byte flip_at on.
  task automatic fill(input int n, input bit md, input int gap, input int kind, input int flip_at);
    int sent = 0;
    int guard = 0;
    bit v, m, r;
    logic [7:0] d;
    while (sent < n && guard < 4000) begin
      v = ($urandom_range(99) >= gap);
      d = (kind == 0) ? 8'(sent) : (kind == 1) ? 8'(sent + 1) : 8'($urandom);
      m = (sent >= flip_at) ? !md : md;
      r = ($urandom_range(15) == 0);
      if (v && !m_held) sent++;
      step(v, d, m, r, 1'b0);
      guard++;
    end
    if (sent < n) chk("fill_timeout", sent, n);
  endtask

  task automatic pulse_aclr();
    bus.i_valid = 1'b0; bus.i_release = 1'b0; sclr = 1'b0;
    aclr = 1'b1;
    #2;
    chk("aclr_fill_cnt", bus.o_fill_cnt, 0);
    chk("aclr_blk_full", bus.o_blk_full, 0);
    chk("aclr_blk_mode", bus.o_blk_mode, 0);
    chk("aclr_in_ready", bus.o_ready, 1);
    chk("aclr_shift_out", bus.o_shift_out, 0);
    chk_vec("aclr_q_large", bus.o_q_large, '0);
    model_reset();
    #1 aclr = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every blk_done pulse must match the oldest predicted block
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [QW-1:0] sm;
    if (bus.o_blk_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL blk_done_unexpected actual=1 expected=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk_vec("blk_q_large", bus.o_q_large, e.q);
        sm = '0;
        sm[SW-1:0] = bus.o_q_small;
        chk_vec("blk_q_small", sm, {{(QW-SW){1'b0}}, e.q[QW-1 -: SW]});
        chk("blk_cnt", bus.o_fill_cnt, e.cnt);
        chk("blk_mode_at_done", bus.o_blk_mode, e.mode);
      end
    end
  end

  initial begin
    aclr = 1'b1; sclr = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = 8'h00; bus.i_mode = 1'b0; bus.i_release = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.o_ready, 1);
    chk("rst_fill_cnt", bus.o_fill_cnt, 0);
    chk("rst_blk_full", bus.o_blk_full, 0);
    chk("rst_blk_done", bus.o_blk_done, 0);
    chk("rst_blk_mode", bus.o_blk_mode, 0);
    chk_vec("rst_q_large", bus.o_q_large, '0);

    // Large block, bytes i%256 back-to-back
    fill(DEPTH_MAX, 1'b1, 0, 0, 100000);
    chk("large_low_byte", bus.o_q_large[7:0], 8'h00);
    chk("large_top_byte", bus.o_q_large[QW-1 -: 8], 8'hFF);
    chk("large_fill_cnt", bus.o_fill_cnt, 768);

    // Backpressure while held
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    chk_vec("held_q_large", bus.o_q_large, model_vec());
    chk("held_fill_cnt", bus.o_fill_cnt, 768);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("chain_first_out", bus.o_shift_out, 8'h00);
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("post_release_cnt", bus.o_fill_cnt, 1);
    chk("chain_second_out", bus.o_shift_out, 8'h01);
    fill(DEPTH_MAX - 1, 1'b1, 25, 2, 100000);

    // sclr together with release clears everything
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk_vec("sclr_q_large", bus.o_q_large, '0);
    chk("sclr_fill_cnt", bus.o_fill_cnt, 0);
    chk("sclr_blk_full", bus.o_blk_full, 0);

    // Small block 0x01..0x84
    fill(DEPTH_SM, 1'b0, 30, 1, 100000);
    chk("small_low_byte", bus.o_q_small[7:0], 8'h01);
    chk("small_top_byte", bus.o_q_small[SW-1 -: 8], 8'h84);
    chk("small_fill_cnt", bus.o_fill_cnt, 132);

    // Mode raised after byte 5 is ignored
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    fill(DEPTH_SM, 1'b0, 20, 2, 5);
    chk("flip_blk_mode", bus.o_blk_mode, 0);
    chk("flip_fill_cnt", bus.o_fill_cnt, 132);

    // Async reset mid-fill, then a normal small block
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    fill(300, 1'b1, 10, 2, 100000);
    pulse_aclr();
    fill(DEPTH_SM, 1'b0, 10, 2, 100000);
    chk("refill_blk_full", bus.o_blk_full, 1);

    // Random blocks with random gaps, hold times and mode changes
    for (int b = 0; b < 6; b++) begin
      bit md;
      md = 1'($urandom_range(1));
      for (int k = $urandom_range(4); k > 0; k--)
        step(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      fill(md ? DEPTH_MAX : DEPTH_SM, md, $urandom_range(50), 2, $urandom_range(200, 1));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
